// File: rtl/nems_cfg_seq.sv
// nems_cfg_seq: column-by-column NEMS relay programming sequencer.
// Each column takes a row-pattern word (LOAD), sets up the rows (SETUP), holds
// the column select for HOLD_CYCLES (PULSE), and deselects the column before
// the rows change (RELEASE). After the last column, DONE is pulsed for one cycle.
// Optional feature macro: NEMS_CFG_ERASE_EN. When it is defined, an ERASE phase
// (rows low, column selected, HOLD_CYCLES long) is inserted before every LOAD.
module nems_cfg_seq #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned NUM_COLS    = 29,
  parameter int unsigned NUM_ROWS    = 30
) (
  input  logic                cfg_clk,
  input  logic                cfg_rst_n,
  input  logic                start,
  input  logic                word_valid,
  input  logic [NUM_ROWS-1:0] word_data,
  output logic                word_ready,
  output logic [NUM_ROWS-1:0] cfgrows,
  output logic [NUM_COLS-1:0] cfgcols,
  output logic [4:0]          col_idx,
  output logic                busy,
  output logic                done
);

  localparam int unsigned COL_W = 5;
  localparam int unsigned CNT_W = 8;

  localparam logic [COL_W-1:0]    LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0]    LAST_HOLD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [NUM_COLS-1:0] COL_ONE   = NUM_COLS'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_PULSE   = 3'd3,
    ST_RELEASE = 3'd4,
`ifdef NEMS_CFG_ERASE_EN
    ST_DONE    = 3'd5,
    ST_ERASE   = 3'd6
`else
    ST_DONE    = 3'd5
`endif
  } state_t;

  // First state of every column: the erase phase when it is built in, otherwise LOAD.
`ifdef NEMS_CFG_ERASE_EN
  localparam state_t ST_COL_ENTRY = ST_ERASE;
`else
  localparam state_t ST_COL_ENTRY = ST_LOAD;
`endif

  state_t               state_q, state_nx;
  logic [COL_W-1:0]     col_q, col_nx;
  logic [CNT_W-1:0]     cnt_q, cnt_nx;
  logic [NUM_ROWS-1:0]  row_q, row_nx;

  logic                 ready_nx, busy_nx, done_nx;
  logic [NUM_ROWS-1:0]  rows_nx;
  logic [NUM_COLS-1:0]  cols_nx;

  assign col_idx = col_q;

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_nx = state_q;
    col_nx   = col_q;
    cnt_nx   = cnt_q;
    row_nx   = row_q;

    case (state_q)
      ST_IDLE: begin
        col_nx = '0;
        cnt_nx = '0;
        if (start) state_nx = ST_COL_ENTRY;
      end
`ifdef NEMS_CFG_ERASE_EN
      ST_ERASE: begin
        if (cnt_q == LAST_HOLD) begin
          cnt_nx   = '0;
          state_nx = ST_LOAD;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_LOAD: begin
        if (word_valid) begin
          row_nx   = word_data;
          state_nx = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_nx   = '0;
        state_nx = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q == LAST_HOLD) begin
          cnt_nx   = '0;
          state_nx = ST_RELEASE;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (col_q == LAST_COL) begin
          state_nx = ST_DONE;
        end else begin
          col_nx   = col_q + COL_W'(1);
          state_nx = ST_COL_ENTRY;
        end
      end
      ST_DONE: begin
        col_nx   = '0;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        col_nx   = '0;
        cnt_nx   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    ready_nx = (state_nx == ST_LOAD);
    busy_nx  = (state_nx != ST_IDLE);
    done_nx  = (state_nx == ST_DONE);
    rows_nx  = '0;
    cols_nx  = '0;
    case (state_nx)
      ST_SETUP, ST_RELEASE: rows_nx = row_nx;
      ST_PULSE: begin
        rows_nx = row_nx;
        cols_nx = COL_ONE << col_nx;
      end
`ifdef NEMS_CFG_ERASE_EN
      ST_ERASE: cols_nx = COL_ONE << col_nx;
`endif
      default: ;
    endcase
  end

  // State, counters, row register and registered outputs; reset clears all at once.
  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfgrows    <= '0;
      cfgcols    <= '0;
    end else begin
      state_q    <= state_nx;
      col_q      <= col_nx;
      cnt_q      <= cnt_nx;
      row_q      <= row_nx;
      word_ready <= ready_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      cfgrows    <= rows_nx;
      cfgcols    <= cols_nx;
    end
  end

endmodule

// File: tb/tb_nems_cfg_seq.sv
// Bench for nems_cfg_seq (HOLD_CYCLES=4); follows NEMS_CFG_ERASE_EN if it is defined.
// Expected column-select segments are queued when a pass is started and
// compared as the monitor observes each segment ending.
module tb_nems_cfg_seq;

  localparam int unsigned HOLD = 4;
  localparam int unsigned NC   = 29;
  localparam int unsigned NR   = 30;
`ifdef NEMS_CFG_ERASE_EN
  localparam int unsigned PER  = 2 * HOLD + 3;
`else
  localparam int unsigned PER  = HOLD + 3;
`endif
  localparam int          LAT    = int'(NC * PER + 1);
  localparam int          BUDGET = 4000;

  logic          cfg_clk = 1'b0;
  logic          cfg_rst_n;
  logic          start;
  logic          word_valid;
  logic [NR-1:0] word_data;
  logic          word_ready;
  logic [NR-1:0] cfgrows;
  logic [NC-1:0] cfgcols;
  logic [4:0]    col_idx;
  logic          busy;
  logic          done;

  typedef struct {
    logic [NC-1:0] cols;
    logic [NR-1:0] rows;
    int            len;
    int            col;
  } seg_t;

  seg_t sb[$];
  int tests;
  int fails;
  int done_cnt;
  int word_idx = 0;
  int idx_base = 0;

  logic [NC-1:0] run_cols;
  logic [NR-1:0] run_rows;
  int            run_len;
  int            run_col;

  nems_cfg_seq #(.HOLD_CYCLES(HOLD), .NUM_COLS(NC), .NUM_ROWS(NR)) dut (
    .cfg_clk    (cfg_clk),
    .cfg_rst_n  (cfg_rst_n),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .cfgrows    (cfgrows),
    .cfgcols    (cfgcols),
    .col_idx    (col_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 cfg_clk = ~cfg_clk;

  // Distinct, nonzero row pattern per column index.
  function automatic logic [NR-1:0] pattern(input int k);
    logic [31:0] v;
    v = 32'(k + 1) | (32'(k) << 8) | (32'h15 << 20);
    return NR'(v);
  endfunction

  assign word_data = pattern(word_idx - idx_base);

  // Counts accepted words so each column gets the next pattern.
  always @(posedge cfg_clk) if (word_valid && word_ready) word_idx <= word_idx + 1;

  task automatic push_col(input int k, input int len);
    seg_t s;
`ifdef NEMS_CFG_ERASE_EN
    s.cols = NC'(1) << k;
    s.rows = '0;
    s.len  = int'(HOLD);
    s.col  = k;
    sb.push_back(s);
`endif
    s.cols = NC'(1) << k;
    s.rows = pattern(k);
    s.len  = len;
    s.col  = k;
    sb.push_back(s);
  endtask

  task automatic close_run();
    seg_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_select: cols=%h rows=%h len=%0d, required no selection",
               run_cols, run_rows, run_len);
    end else begin
      e = sb.pop_front();
      if (run_cols !== e.cols || run_rows !== e.rows || run_len != e.len || run_col != e.col) begin
        fails++;
        $display("FAIL select_col%0d: got cols=%h rows=%h len=%0d idx=%0d, required cols=%h rows=%h len=%0d idx=%0d",
                 e.col, run_cols, run_rows, run_len, run_col, e.cols, e.rows, e.len, e.col);
      end
    end
    run_len = 0;
  endtask

  // Per-cycle observer: one-hot/stability checks, done counting, segment capture.
  task automatic monitor();
    forever begin
      @(negedge cfg_clk);
      tests++;
      if (!$onehot0(cfgcols)) begin
        fails++;
        $display("FAIL onehot: cfgcols=%h, required one-hot or zero", cfgcols);
      end
      if (done) done_cnt++;
      if (run_len > 0 && cfgcols != '0 && cfgcols == run_cols) begin
        tests++;
        if (cfgrows !== run_rows) begin
          fails++;
          $display("FAIL rows_stable: cfgrows=%h, required %h while column selected", cfgrows, run_rows);
        end
        run_len++;
      end else begin
        if (run_len > 0) close_run();
        if (cfgcols != '0) begin
          run_cols = cfgcols;
          run_rows = cfgrows;
          run_len  = 1;
          run_col  = int'(col_idx);
        end
      end
    end
  endtask

  task automatic test_reset();
    cfg_rst_n  = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    #12;
    tests++; if (cfgcols !== '0) begin fails++; $display("FAIL reset_cfgcols: got %h, required 0", cfgcols); end
    tests++; if (cfgrows !== '0) begin fails++; $display("FAIL reset_cfgrows: got %h, required 0", cfgrows); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    tests++; if (word_ready !== 1'b0) begin fails++; $display("FAIL reset_word_ready: got %b, required 0", word_ready); end
    tests++; if (col_idx !== 5'd0) begin fails++; $display("FAIL reset_col_idx: got %0d, required 0", col_idx); end
    @(negedge cfg_clk) cfg_rst_n = 1'b1;
    repeat (5) @(negedge cfg_clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_no_start: busy=%b, required 0", busy); end
  endtask

  // One full pass; optional LOAD stall at column stall_col, optional stray starts.
  task automatic run_pass(input string name, input int exp_lat, input int stall_col, input bit stray);
    int n;
    idx_base = word_idx;
    done_cnt = 0;
    for (int k = 0; k < int'(NC); k++) push_col(k, int'(HOLD));
    @(negedge cfg_clk) start = 1'b1;
    @(negedge cfg_clk) start = 1'b0;
    n = 1;
    fork
      begin
        while (!done && n < BUDGET) begin
          @(negedge cfg_clk);
          n++;
        end
        @(negedge cfg_clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL %s_after_done: done=%b busy=%b, required 0 0", name, done, busy);
        end
      end
      begin
        if (stall_col >= 0) begin
          for (int m = 0; m < BUDGET && !(word_ready && (word_idx - idx_base) == stall_col); m++)
            @(negedge cfg_clk);
          word_valid = 1'b0;
          for (int i = 0; i < 10; i++) begin
            tests++;
            if (word_ready !== 1'b1 || cfgrows !== '0 || cfgcols !== '0) begin
              fails++;
              $display("FAIL %s_stall%0d: word_ready=%b cfgrows=%h cfgcols=%h, required 1 0 0",
                       name, i, word_ready, cfgrows, cfgcols);
            end
            @(negedge cfg_clk);
          end
          word_valid = 1'b1;
        end
      end
      begin
        if (stray) begin
          for (int m = 0; m < BUDGET && !(cfgcols == (NC'(1) << 3) && cfgrows != '0); m++)
            @(negedge cfg_clk);
          start = 1'b1;
          @(negedge cfg_clk) start = 1'b0;
          for (int m = 0; m < BUDGET && !done; m++) @(negedge cfg_clk);
          start = 1'b1;
          @(negedge cfg_clk) start = 1'b0;
        end
      end
    join
    repeat (4) @(negedge cfg_clk);
    tests++;
    if (n != exp_lat) begin
      fails++;
      $display("FAIL %s_latency: done at cycle %0d, required %0d", name, n, exp_lat);
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt);
    end
    tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_complete: %0d selections missing, busy=%b, required 0 0", name, sb.size(), busy);
    end
    sb.delete();
  endtask

  task automatic test_full_pass();
    run_pass("full_pass", LAT, -1, 1'b0);
  endtask

  task automatic test_load_stall();
    run_pass("load_stall", LAT + 10, 5, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_pass("start_ignored", LAT, -1, 1'b1);
  endtask

  task automatic test_reset_mid_pass();
    idx_base = word_idx;
    for (int k = 0; k < 12; k++) push_col(k, int'(HOLD));
    push_col(12, 1);
    @(negedge cfg_clk) start = 1'b1;
    @(negedge cfg_clk) start = 1'b0;
    for (int m = 0; m < BUDGET && !(cfgcols == (NC'(1) << 12) && cfgrows != '0); m++)
      @(negedge cfg_clk);
    #2 cfg_rst_n = 1'b0;
    #1;
    tests++;
    if (cfgcols !== '0 || cfgrows !== '0 || busy !== 1'b0 || done !== 1'b0 || word_ready !== 1'b0 || col_idx !== 5'd0) begin
      fails++;
      $display("FAIL async_reset: cols=%h rows=%h busy=%b done=%b ready=%b idx=%0d, required all 0",
               cfgcols, cfgrows, busy, done, word_ready, col_idx);
    end
    @(negedge cfg_clk) cfg_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge cfg_clk);
      tests++;
      if (busy !== 1'b0 || cfgcols !== '0) begin
        fails++;
        $display("FAIL reset_no_resume%0d: busy=%b cfgcols=%h, required 0 0", i, busy, cfgcols);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_pass_sel: %0d selections missing, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    run_pass("back_to_back_a", LAT, -1, 1'b0);
    run_pass("back_to_back_b", LAT, -1, 1'b0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    done_cnt = 0;
    run_len  = 0;
    run_col  = 0;
    run_cols = '0;
    run_rows = '0;
    start      = 1'b0;
    word_valid = 1'b0;
    cfg_rst_n  = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    word_valid = 1'b1;
    test_full_pass();
    test_load_stall();
    test_start_ignored();
    test_reset_mid_pass();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
